// File: rtl/foc_pkg.sv
// foc_pkg: shared constants and types for the FOC loop arbiter.
// Channel selects, FSM state encoding and operand widths used by
// pi_loop_arbiter and pi_arb_divider.
package foc_pkg;

  localparam int OP_W   = 13;   // engine target / feedback width
  localparam int GAIN_W = 16;   // engine gain width
  localparam int RES_W  = 12;   // engine result width
  localparam int DIV_W  = 5;    // speed divider counter width (SPD_DIV <= 31)
  localparam int WCNT_W = 8;    // wait counter width (TIMEOUT <= 255)

  localparam logic [1:0] CH_SPD = 2'd0;
  localparam logic [1:0] CH_D   = 2'd1;
  localparam logic [1:0] CH_Q   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Widen an engine result to operand width, keeping its sign.
  function automatic logic signed [OP_W-1:0] res_to_op(input logic signed [RES_W-1:0] v);
    return {{(OP_W-RES_W){v[RES_W-1]}}, v};
  endfunction

endpackage

// File: rtl/pi_arb_divider.sv
// pi_arb_divider: counts accepted PWM ticks modulo SPD_DIV and flags the
// tick on which the speed channel is due (count == SPD_DIV-1).
module pi_arb_divider
  import foc_pkg::*;
#(
  parameter int SPD_DIV = 10
)(
  input  logic iClk,
  input  logic iRst_n,
  input  logic iTick,
  output logic oSpd_due
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(SPD_DIV - 1);

  logic [DIV_W-1:0] r_cnt;

  // Advance on accepted ticks only, wrapping after SPD_DIV-1
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cnt <= '0;
    end else if (iTick) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign oSpd_due = iTick && (r_cnt == LAST);

endmodule

// File: rtl/pi_loop_arbiter.sv
// pi_loop_arbiter: schedules the FOC PI loops (speed, d, q) onto one shared
// banked PI engine once per PWM period, and latches the per-channel results.
// Build option: define PI_ARB_SPEED_LOOP_EN to include the speed channel and
// its divider; without it every period runs d then q, the q target comes
// from iIq_set and oIq_ref is tied to 0.
module pi_loop_arbiter
  import foc_pkg::*;
#(
  parameter int SPD_DIV = 10,
  parameter int TIMEOUT = 255
)(
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iPwm_tick,
`ifdef PI_ARB_SPEED_LOOP_EN
  input  logic signed [OP_W-1:0]   iSpd_set,
  input  logic signed [OP_W-1:0]   iSpd_fb,
  input  logic signed [GAIN_W-1:0] iKp_spd,
  input  logic signed [GAIN_W-1:0] iKi_spd,
`else
  input  logic signed [OP_W-1:0]   iIq_set,
`endif
  input  logic signed [OP_W-1:0]   iId_set,
  input  logic signed [OP_W-1:0]   iId_fb,
  input  logic signed [OP_W-1:0]   iIq_fb,
  input  logic signed [GAIN_W-1:0] iKp_cur,
  input  logic signed [GAIN_W-1:0] iKi_cur,
  input  logic                     iErr_clr,
  output logic                     oPi_start,
  output logic [1:0]               oPi_sel,
  output logic signed [OP_W-1:0]   oPi_target,
  output logic signed [OP_W-1:0]   oPi_fb,
  output logic signed [GAIN_W-1:0] oPi_kp,
  output logic signed [GAIN_W-1:0] oPi_ki,
  input  logic signed [RES_W-1:0]  iPi_result,
  input  logic                     iPi_done,
  output logic signed [RES_W-1:0]  oIq_ref,
  output logic signed [RES_W-1:0]  oVd,
  output logic signed [RES_W-1:0]  oVq,
  output logic                     oCycle_done,
  output logic                     oTimeout_err,
  output logic                     oOverrun_err
);

  if (SPD_DIV < 1 || SPD_DIV > 31) begin : g_bad_spd_div
    $error("pi_loop_arbiter: SPD_DIV must be in 1..31");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("pi_loop_arbiter: TIMEOUT must be in 1..255");
  end

  // Last WAIT cycle index; the channel is abandoned at the end of it.
  localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(TIMEOUT - 1);

  arb_state_e                r_state, w_state_nxt;
  logic [2:0]                r_pend, w_pend_nxt;   // indexed by channel select
  logic [1:0]                r_sel, w_sel_nxt;
  logic [WCNT_W-1:0]         r_wait_cnt;
  logic                      w_accept, w_overrun, w_spd_due;
  logic                      w_done, w_tmo, w_load;
  logic signed [OP_W-1:0]    r_target, r_fb, w_target_nxt, w_fb_nxt;
  logic signed [GAIN_W-1:0]  r_kp, r_ki, w_kp_nxt, w_ki_nxt;
  logic signed [RES_W-1:0]   r_vd, r_vq;
  logic                      r_tmo_err, r_ovr_err;

  // Ticks are only taken while idle; anything else is an overrun.
  assign w_accept  = iPwm_tick && (r_state == ST_IDLE);
  assign w_overrun = iPwm_tick && (r_state != ST_IDLE);

`ifdef PI_ARB_SPEED_LOOP_EN
  logic signed [RES_W-1:0] r_iq_ref;

  pi_arb_divider #(
    .SPD_DIV (SPD_DIV)
  ) u_div (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iTick    (w_accept),
    .oSpd_due (w_spd_due)
  );
`else
  assign w_spd_due = 1'b0;
`endif

  // Next state, pending flags and the channel to issue next
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_pend_nxt[CH_D] = 1'b1;
          w_pend_nxt[CH_Q] = 1'b1;
          if (w_spd_due) w_pend_nxt[CH_SPD] = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the timeout cycle still counts as done.
        w_done = iPi_done;
        w_tmo  = !iPi_done && (r_wait_cnt == TMO_LAST);
        if (w_done || w_tmo) begin
          w_pend_nxt  = w_pend_nxt & ~(3'b001 << r_sel);
          w_state_nxt = (|w_pend_nxt) ? ST_ISSUE : ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Priority spd > d > q among what is still pending.
    if (w_pend_nxt[CH_SPD])    w_sel_nxt = CH_SPD;
    else if (w_pend_nxt[CH_D]) w_sel_nxt = CH_D;
    else                       w_sel_nxt = CH_Q;
  end

  assign w_load = (w_state_nxt == ST_ISSUE);

  // Operand and gain selection for the channel about to be issued
  always_comb begin
    w_fb_nxt = iIq_fb;
    w_kp_nxt = iKp_cur;
    w_ki_nxt = iKi_cur;
`ifdef PI_ARB_SPEED_LOOP_EN
    w_target_nxt = res_to_op(r_iq_ref);
`else
    w_target_nxt = iIq_set;
`endif
    case (w_sel_nxt)
`ifdef PI_ARB_SPEED_LOOP_EN
      CH_SPD: begin
        w_target_nxt = iSpd_set;
        w_fb_nxt     = iSpd_fb;
        w_kp_nxt     = iKp_spd;
        w_ki_nxt     = iKi_spd;
      end
`endif
      CH_D: begin
        w_target_nxt = iId_set;
        w_fb_nxt     = iId_fb;
      end
      default: ;
    endcase
  end

  // State register, pending flags and WAIT cycle counter
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state    <= ST_IDLE;
      r_pend     <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + 1'b1 : '0;
    end
  end

  // Engine request registers: loaded on entry to ISSUE, held until the next one
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sel    <= CH_SPD;
      r_target <= '0;
      r_fb     <= '0;
      r_kp     <= '0;
      r_ki     <= '0;
    end else if (w_load) begin
      r_sel    <= w_sel_nxt;
      r_target <= w_target_nxt;
      r_fb     <= w_fb_nxt;
      r_kp     <= w_kp_nxt;
      r_ki     <= w_ki_nxt;
    end
  end

  // Channel results, updated only by a real engine answer (timeouts keep them)
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
`ifdef PI_ARB_SPEED_LOOP_EN
      r_iq_ref <= '0;
`endif
      r_vd <= '0;
      r_vq <= '0;
    end else if (w_done) begin
      case (r_sel)
`ifdef PI_ARB_SPEED_LOOP_EN
        CH_SPD:  r_iq_ref <= iPi_result;
`endif
        CH_D:    r_vd <= iPi_result;
        CH_Q:    r_vq <= iPi_result;
        default: ;
      endcase
    end
  end

  // Sticky error flags; a set event beats iErr_clr in the same cycle
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_tmo_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else begin
      if (w_tmo)         r_tmo_err <= 1'b1;
      else if (iErr_clr) r_tmo_err <= 1'b0;
      if (w_overrun)     r_ovr_err <= 1'b1;
      else if (iErr_clr) r_ovr_err <= 1'b0;
    end
  end

  assign oPi_start    = (r_state == ST_ISSUE);
  assign oCycle_done  = (r_state == ST_DONE);
  assign oPi_sel      = r_sel;
  assign oPi_target   = r_target;
  assign oPi_fb       = r_fb;
  assign oPi_kp       = r_kp;
  assign oPi_ki       = r_ki;
  assign oVd          = r_vd;
  assign oVq          = r_vq;
  assign oTimeout_err = r_tmo_err;
  assign oOverrun_err = r_ovr_err;
`ifdef PI_ARB_SPEED_LOOP_EN
  assign oIq_ref = r_iq_ref;
`else
  assign oIq_ref = '0;
`endif

endmodule

// File: tb/tb_pi_loop_arbiter.sv
// tb_pi_loop_arbiter: directed/randomised bench for pi_loop_arbiter with a
// behavioural engine responder and a period-level reference model.
// Works with and without PI_ARB_SPEED_LOOP_EN.
module tb_pi_loop_arbiter;
  import foc_pkg::*;

  localparam int SPD_DIV = 3;
  localparam int TIMEOUT = 8;
`ifdef PI_ARB_SPEED_LOOP_EN
  localparam bit SPD_EN = 1'b1;
`else
  localparam bit SPD_EN = 1'b0;
`endif

  logic iClk = 1'b0, iRst_n = 1'b0, iPwm_tick = 1'b0, iErr_clr = 1'b0, iPi_done = 1'b0;
  logic signed [12:0] spd_set = '0, spd_fb = '0, iq_set = '0;
  logic signed [12:0] iId_set = '0, iId_fb = '0, iIq_fb = '0;
  logic signed [15:0] kp_spd = '0, ki_spd = '0, iKp_cur = '0, iKi_cur = '0;
  logic signed [11:0] iPi_result = '0;
  logic               oPi_start, oCycle_done, oTimeout_err, oOverrun_err;
  logic [1:0]         oPi_sel;
  logic signed [12:0] oPi_target, oPi_fb;
  logic signed [15:0] oPi_kp, oPi_ki;
  logic signed [11:0] oIq_ref, oVd, oVq;

  pi_loop_arbiter #(.SPD_DIV(SPD_DIV), .TIMEOUT(TIMEOUT)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iPwm_tick(iPwm_tick),
`ifdef PI_ARB_SPEED_LOOP_EN
    .iSpd_set(spd_set), .iSpd_fb(spd_fb), .iKp_spd(kp_spd), .iKi_spd(ki_spd),
`else
    .iIq_set(iq_set),
`endif
    .iId_set(iId_set), .iId_fb(iId_fb), .iIq_fb(iIq_fb),
    .iKp_cur(iKp_cur), .iKi_cur(iKi_cur), .iErr_clr(iErr_clr),
    .oPi_start(oPi_start), .oPi_sel(oPi_sel), .oPi_target(oPi_target), .oPi_fb(oPi_fb),
    .oPi_kp(oPi_kp), .oPi_ki(oPi_ki), .iPi_result(iPi_result), .iPi_done(iPi_done),
    .oIq_ref(oIq_ref), .oVd(oVd), .oVq(oVq), .oCycle_done(oCycle_done),
    .oTimeout_err(oTimeout_err), .oOverrun_err(oOverrun_err)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct {
    int cyc; int sel; int tgt; int fb; int kp; int ki;
  } start_t;
  start_t log_q[$];

  // engine responder state
  int                 cd_cnt = 0, eng_cnt = 0, eng_lat = 4;
  bit                 eng_mute = 1'b0;
  logic [1:0]         eng_ch = '0;
  logic signed [11:0] res_val [3];

  // reference model state
  int m_ticks = 0, m_iq_ref = 0, m_vd = 0, m_vq = 0;
  bit m_tmo = 1'b0, m_ovr = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Engine model and monitor: logs every start, answers eng_lat cycles later.
  initial begin
    start_t e;
    forever begin
      @(negedge iClk);
      if (!iRst_n) begin
        eng_cnt  = 0;
        iPi_done = 1'b0;
      end else begin
        iPi_done = 1'b0;
        if (oCycle_done) cd_cnt++;
        if (oPi_start) begin
          e.cyc = cyc; e.sel = int'(oPi_sel); e.tgt = int'(oPi_target);
          e.fb = int'(oPi_fb); e.kp = int'(oPi_kp); e.ki = int'(oPi_ki);
          log_q.push_back(e);
          eng_ch  = oPi_sel;
          eng_cnt = eng_mute ? 0 : eng_lat;
        end else if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            iPi_done   = 1'b1;
            iPi_result = res_val[eng_ch];
          end
        end
      end
    end
  end

  task automatic randomize_inputs();
    spd_set = 13'($urandom); spd_fb = 13'($urandom); iq_set = 13'($urandom);
    iId_set = 13'($urandom); iId_fb = 13'($urandom); iIq_fb = 13'($urandom);
    kp_spd  = 16'($urandom); ki_spd = 16'($urandom);
    iKp_cur = 16'($urandom); iKi_cur = 16'($urandom);
    for (int i = 0; i < 3; i++) res_val[i] = 12'($urandom);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_start"},  int'(oPi_start), 0);
    check({pfx, "_sel"},    int'(oPi_sel), 0);
    check({pfx, "_target"}, int'(oPi_target), 0);
    check({pfx, "_fb"},     int'(oPi_fb), 0);
    check({pfx, "_kp"},     int'(oPi_kp), 0);
    check({pfx, "_ki"},     int'(oPi_ki), 0);
    check({pfx, "_iqref"},  int'(oIq_ref), 0);
    check({pfx, "_vd"},     int'(oVd), 0);
    check({pfx, "_vq"},     int'(oVq), 0);
    check({pfx, "_cdone"},  int'(oCycle_done), 0);
    check({pfx, "_tmo"},    int'(oTimeout_err), 0);
    check({pfx, "_ovr"},    int'(oOverrun_err), 0);
  endtask

  // One PWM period: tick, let the arbiter run, compare against the model.
  task automatic run_period(input bit mute, input int lat, input bit ovr,
                            input bit ovr_clr, input bit fixed);
    int chans[$];
    int cd0, t0, exp_c, ch, et, ef, ek, ei;
    bit inj, spd;
    randomize_inputs();
    if (fixed) begin
      res_val[CH_SPD] = 12'sd300;
      res_val[CH_D]   = -12'sd50;
      iq_set          = -13'sd100;
    end
    eng_mute = mute;
    eng_lat  = lat;
    spd = SPD_EN && ((m_ticks % SPD_DIV) == SPD_DIV - 1);
    m_ticks++;
    if (spd) chans.push_back(int'(CH_SPD));
    chans.push_back(int'(CH_D));
    chans.push_back(int'(CH_Q));

    @(negedge iClk);
    log_q.delete();
    cd0 = cd_cnt; t0 = cyc; inj = 1'b0;
    iPwm_tick = 1'b1;
    for (int n = 0; n < 500 && cd_cnt == cd0; n++) begin
      @(negedge iClk);
      iPwm_tick = 1'b0;
      iErr_clr  = 1'b0;
      if (ovr && !inj && log_q.size() > 0) begin
        iPwm_tick = 1'b1;
        iErr_clr  = ovr_clr;
        inj       = 1'b1;
      end
    end
    iPwm_tick = 1'b0;
    iErr_clr  = 1'b0;
    check("cycle_done_seen", int'(cd_cnt != cd0), 1);
    repeat (3) @(negedge iClk);
    check("cycle_done_once", cd_cnt - cd0, 1);
    check("n_starts", log_q.size(), chans.size());

    if (ovr && ovr_clr) m_tmo = 1'b0;
    if (ovr) m_ovr = 1'b1;
    exp_c = t0 + 1;
    foreach (chans[i]) begin
      ch = chans[i];
      if (ch == int'(CH_SPD)) begin
        et = int'(spd_set); ef = int'(spd_fb); ek = int'(kp_spd); ei = int'(ki_spd);
      end else if (ch == int'(CH_D)) begin
        et = int'(iId_set); ef = int'(iId_fb); ek = int'(iKp_cur); ei = int'(iKi_cur);
      end else begin
        et = SPD_EN ? m_iq_ref : int'(iq_set);
        ef = int'(iIq_fb); ek = int'(iKp_cur); ei = int'(iKi_cur);
      end
      if (i < log_q.size()) begin
        check($sformatf("sel[%0d]", i),    log_q[i].sel, ch);
        check($sformatf("target[%0d]", i), log_q[i].tgt, et);
        check($sformatf("fb[%0d]", i),     log_q[i].fb, ef);
        check($sformatf("kp[%0d]", i),     log_q[i].kp, ek);
        check($sformatf("ki[%0d]", i),     log_q[i].ki, ei);
        check($sformatf("start_cyc[%0d]", i), log_q[i].cyc, exp_c);
      end
      if (mute) m_tmo = 1'b1;
      else if (ch == int'(CH_SPD)) m_iq_ref = int'(res_val[CH_SPD]);
      else if (ch == int'(CH_D))   m_vd = int'(res_val[CH_D]);
      else                         m_vq = int'(res_val[CH_Q]);
      // answered: next start the cycle after done; abandoned: after TIMEOUT WAIT cycles
      exp_c += mute ? TIMEOUT + 1 : lat + 1;
    end
    check("iq_ref", int'(oIq_ref), m_iq_ref);
    check("vd", int'(oVd), m_vd);
    check("vq", int'(oVq), m_vq);
    check("tmo_err", int'(oTimeout_err), int'(m_tmo));
    check("ovr_err", int'(oOverrun_err), int'(m_ovr));
  endtask

  task automatic clear_errors();
    @(negedge iClk);
    iErr_clr = 1'b1;
    @(negedge iClk);
    iErr_clr = 1'b0;
    m_tmo = 1'b0;
    m_ovr = 1'b0;
    check("clr_tmo", int'(oTimeout_err), 0);
    check("clr_ovr", int'(oOverrun_err), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) res_val[i] = '0;

    // reset state
    repeat (3) @(negedge iClk);
    check_all_zero("reset");
    iRst_n = 1'b1;

    // six periods with a 4-cycle engine, then random engine latency
    for (int k = 0; k < 6; k++) run_period(1'b0, 4, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) run_period(1'b0, $urandom_range(6, 1), 1'b0, 1'b0, 1'b0);

    // align so the fixed-result period is a speed period when speed is built in
    for (int k = 0; k < SPD_DIV && SPD_EN && ((m_ticks % SPD_DIV) != SPD_DIV - 1); k++)
      run_period(1'b0, 3, 1'b0, 1'b0, 1'b0);
    run_period(1'b0, 4, 1'b0, 1'b0, 1'b1);

    // engine never answers: every channel abandoned, results held
    run_period(1'b1, 4, 1'b0, 1'b0, 1'b0);
    clear_errors();

    // done on the very cycle of the timeout counts as done
    run_period(1'b0, TIMEOUT, 1'b0, 1'b0, 1'b0);

    // overrun tick during WAIT, then overrun coinciding with iErr_clr
    run_period(1'b0, 4, 1'b1, 1'b0, 1'b0);
    clear_errors();
    run_period(1'b0, 4, 1'b1, 1'b1, 1'b0);
    clear_errors();
    for (int k = 0; k < SPD_DIV; k++) run_period(1'b0, $urandom_range(5, 1), 1'b0, 1'b0, 1'b0);

    // reset while waiting on the d channel
    for (int k = 0; k < 1 && SPD_EN && ((m_ticks % SPD_DIV) == SPD_DIV - 1); k++)
      run_period(1'b0, 2, 1'b0, 1'b0, 1'b0);
    randomize_inputs();
    eng_mute = 1'b0;
    eng_lat  = 6;
    @(negedge iClk);
    log_q.delete();
    iPwm_tick = 1'b1;
    @(negedge iClk);
    iPwm_tick = 1'b0;
    for (int n = 0; n < 50 && log_q.size() == 0; n++) @(negedge iClk);
    check("rst_first_sel", (log_q.size() > 0) ? log_q[0].sel : -1, int'(CH_D));
    repeat (2) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    m_ticks = 0; m_iq_ref = 0; m_vd = 0; m_vq = 0; m_tmo = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge iClk);
    iRst_n = 1'b1;
    for (int k = 0; k < SPD_DIV + 1; k++) run_period(1'b0, $urandom_range(6, 1), 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
